// File: rtl/pulse_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// pulse_input_conditioner_if
// Groups the two raw switch inputs and the conditioned outputs of
// pulse_input_conditioner into one bundle.
//   sw1, sw2   : raw, bouncy switch levels (driven by the switch side)
//   x1, x2     : clean single pulses toward the downstream sequence detector
//   lvl1, lvl2 : debounced switch levels
//   ovf        : sticky "a press was merged/lost" flag
// Modports:
//   master : the side that owns the switches and observes the results
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface pulse_input_conditioner_if;
    logic sw1;
    logic sw2;
    logic x1;
    logic x2;
    logic lvl1;
    logic lvl2;
    logic ovf;

    modport master (
        output sw1, sw2,
        input  x1, x2, lvl1, lvl2, ovf
    );

    modport slave (
        input  sw1, sw2,
        output x1, x2, lvl1, lvl2, ovf
    );
endinterface

// File: rtl/pulse_input_conditioner.sv
// ---------------------------------------------------------------------------
// pulse_input_conditioner
// Debounces two raw switches, turns each accepted press (rising debounced
// level) into one clean pulse of PULSE_CYCLES cycles followed by an equally
// long guard gap, and serialises the two channels (channel 1 wins ties).
// Ports:
//   cp  : clock, all state changes on the rising edge
//   rd  : synchronous active-high reset
//   bus : pulse_input_conditioner_if.slave (sw1/sw2 in; x1/x2, lvl1/lvl2,
//         ovf out; all outputs come straight from flops)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing samples needed to flip a level
//   PULSE_CYCLES    : pulse width and guard-gap width in cycles
// Build option:
//   INPUT_SYNC_EN   : when defined, sw1/sw2 go through a 2-flop synchronizer
//                     (2 extra cycles of latency) before the debouncers.
// ---------------------------------------------------------------------------
module pulse_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic                            cp,
    input  logic                            rd,
    pulse_input_conditioner_if.slave        bus
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [7:0]     PLS_LAST = 8'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    logic [1:0]          samp_s;
    logic [1:0]          lvl_q;
    logic [1:0]          lvl_d;
    logic [1:0][CW-1:0]  cnt_q;
    logic [1:0][CW-1:0]  cnt_d;
    logic [1:0]          rise_s;
    logic [1:0]          pend_q;
    logic                ovf_q;
    state_t              state_q;
    logic [7:0]          pcnt_q;
    logic                x1_q;
    logic                x2_q;
    logic                dispatch_s;
    logic [1:0]          take_s;

`ifdef INPUT_SYNC_EN
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge cp) begin
        if (rd) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {bus.sw2, bus.sw1};
            sync2_q <= sync1_q;
        end
    end

    assign samp_s = sync2_q;
`else
    assign samp_s = {bus.sw2, bus.sw1};
`endif

    // Debounce next-state: count differing samples, flip the level on the
    // DEBOUNCE_CYCLES-th one; any agreeing sample (a bounce) restarts the count.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        rise_s = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (samp_s[ch] == lvl_q[ch]) begin
                cnt_d[ch] = CNT_ZERO;
            end else if (cnt_q[ch] == CNT_LAST) begin
                lvl_d[ch]  = ~lvl_q[ch];
                cnt_d[ch]  = CNT_ZERO;
                rise_s[ch] = ~lvl_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge cp) begin
        if (rd) begin
            lvl_q <= 2'b00;
            cnt_q <= {(2*CW){1'b0}};
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    // The FSM can launch a pulse while idle, and also on the last GAP cycle so
    // that back-to-back pulses are separated by exactly PULSE_CYCLES low cycles.
    always_comb begin
        if (state_q == ST_IDLE) begin
            dispatch_s = 1'b1;
        end else if ((state_q == ST_GAP) && (pcnt_q == PLS_LAST)) begin
            dispatch_s = 1'b1;
        end else begin
            dispatch_s = 1'b0;
        end
        if (dispatch_s && pend_q[0]) begin
            take_s = 2'b01;
        end else if (dispatch_s && pend_q[1]) begin
            take_s = 2'b10;
        end else begin
            take_s = 2'b00;
        end
    end

    // Pending press flags and sticky overflow; a new press wins over the
    // same-edge consumption of the previous one, which is then not a loss.
    always_ff @(posedge cp) begin
        if (rd) begin
            pend_q <= 2'b00;
            ovf_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rise_s[ch]) begin
                    pend_q[ch] <= 1'b1;
                end else if (take_s[ch]) begin
                    pend_q[ch] <= 1'b0;
                end else begin
                    pend_q[ch] <= pend_q[ch];
                end
            end
            if ((rise_s & pend_q & ~take_s) != 2'b00) begin
                ovf_q <= 1'b1;
            end else begin
                ovf_q <= ovf_q;
            end
        end
    end

    // Output FSM with registered pulse outputs.
    always_ff @(posedge cp) begin
        if (rd) begin
            state_q <= ST_IDLE;
            pcnt_q  <= 8'd0;
            x1_q    <= 1'b0;
            x2_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pcnt_q <= 8'd0;
                    if (take_s[0]) begin
                        state_q <= ST_P1;
                        x1_q    <= 1'b1;
                    end else if (take_s[1]) begin
                        state_q <= ST_P2;
                        x2_q    <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_P1, ST_P2: begin
                    if (pcnt_q == PLS_LAST) begin
                        state_q <= ST_GAP;
                        pcnt_q  <= 8'd0;
                        x1_q    <= 1'b0;
                        x2_q    <= 1'b0;
                    end else begin
                        pcnt_q  <= pcnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (pcnt_q == PLS_LAST) begin
                        pcnt_q <= 8'd0;
                        if (take_s[0]) begin
                            state_q <= ST_P1;
                            x1_q    <= 1'b1;
                        end else if (take_s[1]) begin
                            state_q <= ST_P2;
                            x2_q    <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        pcnt_q <= pcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pcnt_q  <= 8'd0;
                    x1_q    <= 1'b0;
                    x2_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x1   = x1_q;
    assign bus.x2   = x2_q;
    assign bus.lvl1 = lvl_q[0];
    assign bus.lvl2 = lvl_q[1];
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_pulse_input_conditioner
// Two instances share the same switch stimulus: a short-pulse one
// (PULSE_CYCLES=2) and a long-pulse one (PULSE_CYCLES=16) that can be kept
// busy long enough for a press to be merged. A reference model computes
// levels from a sliding window of samples and pulses from a "busy until"
// schedule; every cycle all outputs of both instances are compared, plus
// directed latency/ordering checks for the listed scenarios.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_input_conditioner;
    localparam int DEB = 4;
    localparam int PS  = 2;
    localparam int PL  = 16;
`ifdef INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic cp = 1'b0;
    logic rd;
    always #5 cp = ~cp;

    pulse_input_conditioner_if bus_s();
    pulse_input_conditioner_if bus_l();

    pulse_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PS)) dut_s (
        .cp(cp), .rd(rd), .bus(bus_s.slave));
    pulse_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PL)) dut_l (
        .cp(cp), .rd(rd), .bus(bus_l.slave));

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // reference model state
    logic [1:0]  pipe_a = 2'b00;
    logic [1:0]  pipe_b = 2'b00;
    logic [15:0] hist [2];
    logic [1:0]  m_lvl = 2'b00;
    logic        m_pend [2][2];
    logic        m_ovf [2];
    int          m_start [2];
    int          m_ch [2];
    int          m_free [2];

    // monitors
    int   np [2][2];
    int   hc [2][2];
    int   ovl [2];
    logic px [2][2];
    logic plv1 = 1'b0;
    int   lvl1_rise, x1_rise, x1_fall, x2_rise;
    int   order_q [$];

    function automatic int plen(input int i);
        return (i == 0) ? PS : PL;
    endfunction

    function automatic logic exp_x(input int i, input int c);
        return (m_ch[i] == c) && (edge_n >= m_start[i]) && (edge_n < m_start[i] + plen(i));
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [1:0] swv);
        logic [1:0] samp;
        logic [1:0] rise;
        logic       all_diff;
        edge_n++;
        if (r) begin
            pipe_a = 2'b00;
            pipe_b = 2'b00;
            hist[0] = 16'h0000;
            hist[1] = 16'h0000;
            m_lvl = 2'b00;
            for (int i = 0; i < 2; i++) begin
                m_pend[i][0] = 1'b0;
                m_pend[i][1] = 1'b0;
                m_ovf[i]     = 1'b0;
                m_start[i]   = -1000;
                m_ch[i]      = 0;
                m_free[i]    = edge_n + 1;
            end
        end else begin
            samp = (LAT == 2) ? pipe_b : swv;
            pipe_b = pipe_a;
            pipe_a = swv;
            rise = 2'b00;
            // level flips when the last DEB samples all disagree with it
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch] = {hist[ch][14:0], samp[ch]};
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++) begin
                    if (hist[ch][k] == m_lvl[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    rise[ch]  = ~m_lvl[ch];
                    m_lvl[ch] = ~m_lvl[ch];
                end
            end
            // a pulse starting at edge s occupies edges s..s+2P-1
            for (int i = 0; i < 2; i++) begin
                if (edge_n >= m_free[i]) begin
                    for (int c = 0; c < 2; c++) begin
                        if (m_pend[i][c] && (edge_n >= m_free[i])) begin
                            m_start[i]   = edge_n;
                            m_ch[i]      = c;
                            m_free[i]    = edge_n + 2 * plen(i);
                            m_pend[i][c] = 1'b0;
                        end
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (rise[c]) begin
                        if (m_pend[i][c]) m_ovf[i] = 1'b1;
                        m_pend[i][c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic clr_mon();
        for (int i = 0; i < 2; i++) begin
            ovl[i] = 0;
            for (int c = 0; c < 2; c++) begin
                np[i][c] = 0;
                hc[i][c] = 0;
            end
        end
        lvl1_rise = -1;
        x1_rise   = -1;
        x1_fall   = -1;
        x2_rise   = -1;
        order_q.delete();
    endtask

    task automatic step(input logic s1, input logic s2, input logic r);
        logic [1:0] obs;
        @(negedge cp);
        bus_s.sw1 = s1; bus_s.sw2 = s2;
        bus_l.sw1 = s1; bus_l.sw2 = s2;
        rd = r;
        @(posedge cp);
        model_edge(r, {s2, s1});
        #1;
        chk_b("x1_s",   bus_s.x1,   exp_x(0, 0));
        chk_b("x2_s",   bus_s.x2,   exp_x(0, 1));
        chk_b("lvl1_s", bus_s.lvl1, m_lvl[0]);
        chk_b("lvl2_s", bus_s.lvl2, m_lvl[1]);
        chk_b("ovf_s",  bus_s.ovf,  m_ovf[0]);
        chk_b("x1_l",   bus_l.x1,   exp_x(1, 0));
        chk_b("x2_l",   bus_l.x2,   exp_x(1, 1));
        chk_b("lvl1_l", bus_l.lvl1, m_lvl[0]);
        chk_b("lvl2_l", bus_l.lvl2, m_lvl[1]);
        chk_b("ovf_l",  bus_l.ovf,  m_ovf[1]);
        for (int i = 0; i < 2; i++) begin
            obs = (i == 0) ? {bus_s.x2, bus_s.x1} : {bus_l.x2, bus_l.x1};
            if (obs == 2'b11) ovl[i]++;
            for (int c = 0; c < 2; c++) begin
                if (obs[c] === 1'b1) hc[i][c]++;
                if ((obs[c] === 1'b1) && !px[i][c]) begin
                    np[i][c]++;
                    if (i == 0) begin
                        order_q.push_back(c + 1);
                        if (c == 0 && x1_rise < 0) x1_rise = edge_n;
                        if (c == 1 && x2_rise < 0) x2_rise = edge_n;
                    end
                end
                if ((obs[c] !== 1'b1) && px[i][c] && i == 0 && c == 0 && x1_fall < 0)
                    x1_fall = edge_n;
                px[i][c] = (obs[c] === 1'b1);
            end
        end
        if ((bus_s.lvl1 === 1'b1) && !plv1 && lvl1_rise < 0) lvl1_rise = edge_n;
        plv1 = (bus_s.lvl1 === 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int r0;
        int o0, o1, o2;
        logic s1, s2, rr;
        int len;

        rd = 1'b1;
        bus_s.sw1 = 1'b0; bus_s.sw2 = 1'b0;
        bus_l.sw1 = 1'b0; bus_l.sw2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            px[i][0] = 1'b0;
            px[i][1] = 1'b0;
        end
        hist[0] = 16'h0000;
        hist[1] = 16'h0000;
        clr_mon();

        // reset
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk_b("rst_x1", bus_s.x1, 1'b0);
        chk_b("rst_ovf", bus_s.ovf, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // clean press on channel 1
        clr_mon();
        step(1'b1, 1'b0, 1'b0);
        t0 = edge_n;
        repeat (19) step(1'b1, 1'b0, 1'b0);
        chk_i("press_lvl_latency", lvl1_rise - t0, LAT + DEB - 1);
        chk_i("press_x1_latency",  x1_rise - lvl1_rise, 1);
        chk_i("press_x1_width",    hc[0][0], PS);
        chk_i("press_x2_quiet",    hc[0][1], 0);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // bounce then a real press
        clr_mon();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk_i("bounce_lvl_rise", lvl1_rise, -1);
        chk_i("bounce_no_pulse", np[0][0], 0);
        repeat (14) step(1'b1, 1'b0, 1'b0);
        chk_i("bounce_one_pulse", np[0][0], 1);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // simultaneous press on both channels
        clr_mon();
        repeat (20) step(1'b1, 1'b1, 1'b0);
        chk_i("simul_x1_width", hc[0][0], PS);
        chk_i("simul_x2_width", hc[0][1], PS);
        chk_i("simul_overlap",  ovl[0], 0);
        chk_i("simul_gap",      x2_rise - x1_fall, PS);
        chk_i("simul_order",    x2_rise - x1_rise, 2 * PS);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // sequence x1, x2, x2
        clr_mon();
        repeat (10) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);
        o0 = (order_q.size() > 0) ? order_q[0] : 0;
        o1 = (order_q.size() > 1) ? order_q[1] : 0;
        o2 = (order_q.size() > 2) ? order_q[2] : 0;
        chk_i("seq_count", order_q.size(), 3);
        chk_i("seq_first", o0, 1);
        chk_i("seq_second", o1, 2);
        chk_i("seq_third", o2, 2);
        chk_b("seq_ovf", bus_s.ovf, 1'b0);

        // overflow on the long-pulse instance
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        clr_mon();
        for (int k = 0; k < 48; k++) begin
            s2 = ((k >= 2) && (k < 8)) || ((k >= 14) && (k < 20));
            step(1'b1, s2, 1'b0);
        end
        chk_i("ovf_single_x2", np[1][1], 1);
        chk_b("ovf_set", bus_l.ovf, 1'b1);
        chk_b("ovf_short_clear", bus_s.ovf, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk_b("ovf_sticky", bus_l.ovf, 1'b1);
        chk_i("ovf_no_second_x2", np[1][1], 1);
        step(1'b0, 1'b0, 1'b1);
        chk_b("ovf_reset", bus_l.ovf, 1'b0);

        // reset in the middle of a pulse
        repeat (12) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 30 && bus_s.x1 !== 1'b1; k++) step(1'b1, 1'b0, 1'b0);
        chk_b("rstmid_reach_x1", bus_s.x1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_b("rstmid_x1_low", bus_s.x1, 1'b0);
        chk_b("rstmid_lvl1_low", bus_s.lvl1, 1'b0);
        clr_mon();
        step(1'b1, 1'b0, 1'b0);
        r0 = edge_n;
        repeat (15) step(1'b1, 1'b0, 1'b0);
        chk_i("rstmid_repress_latency", x1_rise - r0, LAT + DEB);
        chk_i("rstmid_one_pulse", np[0][0], 1);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            s1  = 1'($urandom_range(0, 1));
            s2  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 15) == 0);
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) step(s1, s2, (j == 0) ? rr : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
